// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage mux, 2R/1W integer register file with
// same-cycle write-to-read bypass and a 64-bit committed-write counter.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   mem_data_i  load data from MEM/WB
//   ex_res_i    ALU result from MEM/WB
//   rd_i        destination index from MEM/WB
//   regwrite_i  write-back enable from MEM/WB
//   memtoreg_i  1: write back mem_data_i, 0: write back ex_res_i
//   rs1_i       read port 1 index (decode)
//   rs2_i       read port 2 index (decode)
//   rs1_data_o  read port 1 data (combinational)
//   rs2_data_o  read port 2 data (combinational)
//   wb_data_o   selected write-back value (to forwarding)
//   wb_cnt_o    number of committed register writes, wraps

module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [XLEN-1:0] ex_res_i,
  input  logic [4:0]      rd_i,
  input  logic            regwrite_i,
  input  logic            memtoreg_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [63:0]     wb_cnt_o
);

  localparam logic [5:0] NREG_W = 6'(NREG);

  logic [XLEN-1:0] rf_q [1:NREG-1];
  logic [63:0]     cnt_q;

  logic rd_ok;
  logic rs1_ok;
  logic rs2_ok;
  logic commit;

  assign rd_ok  = {1'b0, rd_i}  < NREG_W;
  assign rs1_ok = {1'b0, rs1_i} < NREG_W;
  assign rs2_ok = {1'b0, rs2_i} < NREG_W;

  assign wb_data_o = memtoreg_i ? mem_data_i : ex_res_i;

  // x0 is never a commit; this also keeps it out of the bypass.
  assign commit = regwrite_i && (rd_i != 5'd0) && rd_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 1; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit) begin
      rf_q[rd_i] <= wb_data_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign wb_cnt_o = cnt_q;

  // Read port 1: zero index wins, then bypass, then storage.
  logic r1_zero;
  logic r1_byp;

  assign r1_zero = (rs1_i == 5'd0) || !rs1_ok;
  assign r1_byp  = !r1_zero && commit && (rs1_i == rd_i);

  always_comb begin
    rs1_data_o = '0;
    unique case (1'b1)
      r1_zero: rs1_data_o = '0;
      r1_byp:  rs1_data_o = wb_data_o;
      default: rs1_data_o = rf_q[rs1_i];
    endcase
  end

  // Read port 2: same priority as port 1.
  logic r2_zero;
  logic r2_byp;

  assign r2_zero = (rs2_i == 5'd0) || !rs2_ok;
  assign r2_byp  = !r2_zero && commit && (rs2_i == rd_i);

  always_comb begin
    rs2_data_o = '0;
    unique case (1'b1)
      r2_zero: rs2_data_o = '0;
      r2_byp:  rs2_data_o = wb_data_o;
      default: rs2_data_o = rf_q[rs2_i];
    endcase
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed bench for wb_regfile.
// Inputs change after negedge; outputs sampled #1 after changes/edges.

module tb_wb_regfile;

  logic        clk_i;
  logic        rst_ni;
  logic [63:0] mem_data_i;
  logic [63:0] ex_res_i;
  logic [4:0]  rd_i;
  logic        regwrite_i;
  logic        memtoreg_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [63:0] rs1_data_o;
  logic [63:0] rs2_data_o;
  logic [63:0] wb_data_o;
  logic [63:0] wb_cnt_o;

  int errs;
  int checks;

  wb_regfile #(
    .XLEN(64),
    .NREG(32)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .mem_data_i(mem_data_i),
    .ex_res_i(ex_res_i),
    .rd_i(rd_i),
    .regwrite_i(regwrite_i),
    .memtoreg_i(memtoreg_i),
    .rs1_i(rs1_i),
    .rs2_i(rs2_i),
    .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o),
    .wb_data_o(wb_data_o),
    .wb_cnt_o(wb_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] rd,
                    input logic mtr,
                    input logic [63:0] val);
    @(negedge clk_i);
    regwrite_i = 1'b1;
    memtoreg_i = mtr;
    rd_i       = rd;
    if (mtr) mem_data_i = val;
    else     ex_res_i   = val;
    @(posedge clk_i);
    #1;
    regwrite_i = 1'b0;
  endtask

  task automatic rd2(input logic [4:0] a,
                     input logic [4:0] b);
    rs1_i = a;
    rs2_i = b;
    #1;
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst_ni     = 1'b0;
    mem_data_i = '0;
    ex_res_i   = '0;
    rd_i       = '0;
    regwrite_i = 1'b0;
    memtoreg_i = 1'b0;
    rs1_i      = '0;
    rs2_i      = '0;

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_cnt", wb_cnt_o, 64'd0);

    // Scenario 1
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd2(5'd5, 5'd31);
    chk("s1_rs1", rs1_data_o, 64'd0);
    chk("s1_rs2", rs2_data_o, 64'd0);
    chk("s1_cnt", wb_cnt_o, 64'd0);

    // wb mux independent of regwrite
    memtoreg_i = 1'b1;
    mem_data_i = 64'h55;
    ex_res_i   = 64'h66;
    #1;
    chk("mux_mem", wb_data_o, 64'h55);
    memtoreg_i = 1'b0;
    #1;
    chk("mux_alu", wb_data_o, 64'h66);

    // Scenario 2
    wr(5'd7, 1'b0, 64'hDEAD_BEEF);
    rd2(5'd7, 5'd0);
    chk("s2_rs1", rs1_data_o, 64'hDEAD_BEEF);
    chk("s2_cnt", wb_cnt_o, 64'd1);

    // Scenario 3: bypass before the edge
    @(negedge clk_i);
    regwrite_i = 1'b1;
    memtoreg_i = 1'b1;
    mem_data_i = 64'h1234;
    rd_i       = 5'd3;
    rd2(5'd3, 5'd3);
    chk("s3_byp1", rs1_data_o, 64'h1234);
    chk("s3_byp2", rs2_data_o, 64'h1234);
    chk("s3_precnt", wb_cnt_o, 64'd1);
    @(posedge clk_i);
    #1;
    regwrite_i = 1'b0;
    rd2(5'd3, 5'd7);
    chk("s3_st", rs1_data_o, 64'h1234);
    chk("s3_x7", rs2_data_o, 64'hDEAD_BEEF);
    chk("s3_cnt", wb_cnt_o, 64'd2);

    // Scenario 4: x0 protection
    @(negedge clk_i);
    regwrite_i = 1'b1;
    memtoreg_i = 1'b0;
    ex_res_i   = 64'hFFFF;
    rd_i       = 5'd0;
    rd2(5'd0, 5'd0);
    chk("s4_byp0", rs1_data_o, 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    regwrite_i = 1'b0;
    rd2(5'd0, 5'd0);
    chk("s4_rs1", rs1_data_o, 64'd0);
    chk("s4_cnt", wb_cnt_o, 64'd2);

    // back-to-back to x9
    wr(5'd9, 1'b0, 64'h11);
    wr(5'd9, 1'b1, 64'h22);
    rd2(5'd9, 5'd9);
    chk("b2b_x9", rs1_data_o, 64'h22);
    chk("b2b_cnt", wb_cnt_o, 64'd4);

    // Scenario 5
    wr(5'd9, 1'b0, 64'hA5);
    rd2(5'd9, 5'd7);
    chk("s5_pre", rs1_data_o, 64'hA5);
    chk("s5_precnt", wb_cnt_o, 64'd5);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("s5_x9", rs1_data_o, 64'd0);
    chk("s5_x7", rs2_data_o, 64'd0);
    chk("s5_cnt", wb_cnt_o, 64'd0);

    // bypass still live in reset, but no write on the edge
    regwrite_i = 1'b1;
    memtoreg_i = 1'b0;
    ex_res_i   = 64'h77;
    rd_i       = 5'd9;
    #1;
    chk("rst_byp", rs1_data_o, 64'h77);
    @(posedge clk_i);
    #1;
    regwrite_i = 1'b0;
    #1;
    chk("rst_nowr", rs1_data_o, 64'd0);
    chk("rst_nocnt", wb_cnt_o, 64'd0);

    // first commit after release
    @(negedge clk_i);
    rst_ni = 1'b1;
    wr(5'd4, 1'b0, 64'h44);
    rd2(5'd4, 5'd9);
    chk("first_x4", rs1_data_o, 64'h44);
    chk("first_x9", rs2_data_o, 64'd0);
    chk("first_cnt", wb_cnt_o, 64'd1);

    // Scenario 6: counter wrap
    @(negedge clk_i);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("s6_max", wb_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
    wr(5'd5, 1'b1, 64'hC0DE);
    rd2(5'd5, 5'd4);
    chk("s6_wrap", wb_cnt_o, 64'd0);
    chk("s6_x5", rs1_data_o, 64'hC0DE);
    chk("s6_x4", rs2_data_o, 64'h44);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
